// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] inst_addr_t;
  typedef logic [6:0]  opcode_t;

  localparam opcode_t LOAD_OPCODE = 7'b0000011;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_WAIT  = 2'd1,
    JUMP_PEND = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare between ID source registers and a load destination in EX.
// Latency: combinational; backpressure: none, the result is consumed by the controller.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter opcode_t LOAD_OPC = LOAD_OPCODE
) (
  input  reg_addr_t id_rs1_addr,
  input  logic      id_rs1_re,
  input  reg_addr_t id_rs2_addr,
  input  logic      id_rs2_re,
  input  opcode_t   ex_opcode,
  input  reg_addr_t ex_rd_addr,
  input  logic      ex_we,
  output logic      lu_hazard
);

  logic load_wr;
  logic rs1_hit;
  logic rs2_hit;

  // x0 never carries a dependency, so a load targeting it cannot stall ID.
  assign load_wr   = (ex_opcode == LOAD_OPC) && ex_we && (ex_rd_addr != '0);
  assign rs1_hit   = id_rs1_re && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit   = id_rs2_re && (id_rs2_addr == ex_rd_addr);
  assign lu_hazard = load_wr && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect controller with divide and fetch-wait sequencing.
// Latency: control outputs are combinational (0 cycles); backpressure: ibus_wait_i holds PC, divider holds pipe until done.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int      CNT_W    = 32,
  parameter opcode_t LOAD_OPC = LOAD_OPCODE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  reg_addr_t        id_rs1_addr_i,
  input  logic             id_rs1_re_i,
  input  reg_addr_t        id_rs2_addr_i,
  input  logic             id_rs2_re_i,
  input  opcode_t          ex_opcode_i,
  input  reg_addr_t        ex_rd_addr_i,
  input  logic             ex_we_i,
  input  logic             ex_jump_i,
  input  inst_addr_t       ex_jump_addr_i,
  input  logic             ex_div_start_i,
  input  logic             div_done_i,
  input  logic             ibus_wait_i,
  output logic             pc_hold_o,
  output logic             if_id_hold_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             jump_flag_o,
  output inst_addr_t       jump_addr_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  ctrl_state_e      state_q;
  ctrl_state_e      state_nxt;
  inst_addr_t       pend_addr_q;
  logic             pend_load;
  logic             lu_hazard;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  pipe_hazard_ctrl_hazard_detect #(
    .LOAD_OPC (LOAD_OPC)
  ) u_hazard_detect (
    .id_rs1_addr (id_rs1_addr_i),
    .id_rs1_re   (id_rs1_re_i),
    .id_rs2_addr (id_rs2_addr_i),
    .id_rs2_re   (id_rs2_re_i),
    .ex_opcode   (ex_opcode_i),
    .ex_rd_addr  (ex_rd_addr_i),
    .ex_we       (ex_we_i),
    .lu_hazard   (lu_hazard)
  );

  always_comb begin
    pc_hold_o      = 1'b0;
    if_id_hold_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    jump_flag_o    = 1'b0;
    jump_addr_o    = '0;
    pend_load      = 1'b0;
    state_nxt      = state_q;
    unique case (state_q)
      RUN: begin
        if (ex_jump_i) begin
          if_id_flush_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
          if (!ibus_wait_i) begin
            jump_flag_o = 1'b1;
            jump_addr_o = ex_jump_addr_i;
          end else begin
            // Fetch cannot accept the redirect yet; park the target.
            pend_load = 1'b1;
            state_nxt = JUMP_PEND;
          end
        end else if (ex_div_start_i) begin
          pc_hold_o      = 1'b1;
          if_id_hold_o   = 1'b1;
          id_ex_bubble_o = 1'b1;
          state_nxt      = DIV_WAIT;
        end else if (lu_hazard) begin
          pc_hold_o      = 1'b1;
          if_id_hold_o   = 1'b1;
          id_ex_bubble_o = 1'b1;
        end else if (ibus_wait_i) begin
          pc_hold_o     = 1'b1;
          if_id_flush_o = 1'b1;
        end
      end
      DIV_WAIT: begin
        if (div_done_i) begin
          state_nxt = RUN;
        end else begin
          pc_hold_o      = 1'b1;
          if_id_hold_o   = 1'b1;
          id_ex_bubble_o = 1'b1;
        end
      end
      JUMP_PEND: begin
        if (ibus_wait_i) begin
          pc_hold_o      = 1'b1;
          if_id_flush_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
        end else begin
          jump_flag_o = 1'b1;
          jump_addr_o = pend_addr_q;
          state_nxt   = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pend_addr_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (pend_load) begin
        pend_addr_q <= ex_jump_addr_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_hold_o) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (jump_flag_o) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized check of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] LD_OPC  = 7'b0000011;
  localparam logic [6:0] ALU_OPC = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_re, id_rs2_re, ex_we;
  logic [6:0]  ex_opcode;
  logic        ex_jump, ex_div_start, div_done, ibus_wait;
  logic [31:0] ex_jump_addr;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_bubble, jump_flag;
  logic [31:0] jump_addr;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;

  // Model state: 0 = running, 1 = waiting on divider, 2 = redirect parked.
  int          m_state;
  logic [31:0] m_pend;
  logic [31:0] m_stall;
  logic [31:0] m_flush;
  logic [4:0]  e_flags;
  logic [31:0] e_addr;
  int          e_next;

  pipe_hazard_ctrl #(.CNT_W(32), .LOAD_OPC(7'b0000011)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1_addr_i  (id_rs1_addr),
    .id_rs1_re_i    (id_rs1_re),
    .id_rs2_addr_i  (id_rs2_addr),
    .id_rs2_re_i    (id_rs2_re),
    .ex_opcode_i    (ex_opcode),
    .ex_rd_addr_i   (ex_rd_addr),
    .ex_we_i        (ex_we),
    .ex_jump_i      (ex_jump),
    .ex_jump_addr_i (ex_jump_addr),
    .ex_div_start_i (ex_div_start),
    .div_done_i     (div_done),
    .ibus_wait_i    (ibus_wait),
    .pc_hold_o      (pc_hold),
    .if_id_hold_o   (if_id_hold),
    .if_id_flush_o  (if_id_flush),
    .id_ex_bubble_o (id_ex_bubble),
    .jump_flag_o    (jump_flag),
    .jump_addr_o    (jump_addr),
    .state_o        (state),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  assign flags = {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, jump_flag};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: {pc_hold, if_id_hold, if_id_flush, bubble, jump_flag}.
  function automatic void model_eval(output logic [4:0] f, output logic [31:0] a, output int nxt);
    logic lu;
    lu = (ex_opcode == LD_OPC) && ex_we && (ex_rd_addr != 5'd0) &&
         ((id_rs1_re && id_rs1_addr == ex_rd_addr) || (id_rs2_re && id_rs2_addr == ex_rd_addr));
    f = 5'b00000; a = 32'd0; nxt = m_state;
    if (m_state == 0) begin
      if (ex_jump && !ibus_wait) begin f = 5'b00111; a = ex_jump_addr; end
      else if (ex_jump)          begin f = 5'b00110; nxt = 2; end
      else if (ex_div_start)     begin f = 5'b11010; nxt = 1; end
      else if (lu)               f = 5'b11010;
      else if (ibus_wait)        f = 5'b10100;
    end else if (m_state == 1) begin
      if (div_done) nxt = 0;
      else          f = 5'b11010;
    end else begin
      if (ibus_wait) f = 5'b10110;
      else begin f = 5'b00001; a = m_pend; nxt = 0; end
    end
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_now(input string tag);
    model_eval(e_flags, e_addr, e_next);
    checks++;
    assert (flags === e_flags) else begin
      failures++;
      $error("FAIL %s flags got=%b exp=%b", tag, flags, e_flags);
    end
    check_val({tag, "_addr"},  jump_addr, e_addr);
    check_val({tag, "_state"}, {30'd0, state}, m_state);
    check_val({tag, "_stall"}, stall_cnt, m_stall);
    check_val({tag, "_flush"}, flush_cnt, m_flush);
  endtask

  // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
  task automatic step(input string tag);
    #1;
    check_now(tag);
    @(posedge clk);
    m_stall = m_stall + {31'd0, e_flags[4]};
    m_flush = m_flush + {31'd0, e_flags[0]};
    if (m_state == 0 && ex_jump && ibus_wait) m_pend = ex_jump_addr;
    m_state = e_next;
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_rs1_re = 1'b0; id_rs2_re = 1'b0; ex_we = 1'b0; ex_opcode = ALU_OPC;
    ex_jump = 1'b0; ex_jump_addr = 32'd0; ex_div_start = 1'b0;
    div_done = 1'b0; ibus_wait = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0; m_pend = 32'd0; m_stall = 32'd0; m_flush = 32'd0;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    #3;
    check_now("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use on rs1, then the bubble clears it.
    ex_opcode = LD_OPC; ex_we = 1'b1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_rs1_re = 1'b1;
    step("lu_rs1");
    idle();
    step("lu_clear");
    check_val("lu_stall_cnt", stall_cnt, 32'd1);
    ex_opcode = LD_OPC; ex_we = 1'b1; ex_rd_addr = 5'd0;
    id_rs1_addr = 5'd0; id_rs1_re = 1'b1;
    step("lu_rd0");
    ex_rd_addr = 5'd9; id_rs2_addr = 5'd9; id_rs2_re = 1'b1; id_rs1_re = 1'b0;
    step("lu_rs2");
    idle();

    // Divide: start cycle + 7 waits, released on done.
    ex_div_start = 1'b1;
    step("div_start");
    ex_div_start = 1'b0;
    for (int i = 0; i < 7; i++) step("div_wait");
    div_done = 1'b1;
    step("div_done");
    div_done = 1'b0;
    step("div_after");
    check_val("div_stall_cnt", stall_cnt, 32'd10);
    check_val("div_state_run", {30'd0, state}, 32'd0);

    // Immediate redirect.
    ex_jump = 1'b1; ex_jump_addr = 32'h0000_0100;
    step("jump_now");
    idle();
    step("jump_now_after");
    check_val("jump_flush_cnt", flush_cnt, 32'd1);

    // Redirect while fetch stalls for 3 cycles.
    ex_jump = 1'b1; ex_jump_addr = 32'h0000_0200; ibus_wait = 1'b1;
    step("jpend_enter");
    ex_jump = 1'b0; ex_jump_addr = 32'hdead_beef;
    step("jpend_wait1");
    step("jpend_wait2");
    ibus_wait = 1'b0;
    check_val("jpend_state", {30'd0, state}, 32'd2);
    step("jpend_fire");
    check_val("jpend_flush_cnt", flush_cnt, 32'd2);

    // Jump beats a simultaneous load-use.
    ex_jump = 1'b1; ex_jump_addr = 32'h0000_0300;
    ex_opcode = LD_OPC; ex_we = 1'b1; ex_rd_addr = 5'd7;
    id_rs1_addr = 5'd7; id_rs1_re = 1'b1;
    step("jump_vs_lu");
    idle();

    // Asynchronous reset in the middle of a divide.
    ex_div_start = 1'b1;
    step("rst_div_start");
    ex_div_start = 1'b0;
    step("rst_div_wait");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_now("rst_async");
    check_val("rst_state", {30'd0, state}, 32'd0);
    check_val("rst_stall", stall_cnt, 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 2000; n++) begin
      ex_jump      = ($urandom_range(0, 9) == 0);
      ex_jump_addr = $urandom;
      ex_div_start = ($urandom_range(0, 7) == 0);
      div_done     = ($urandom_range(0, 3) == 0);
      ibus_wait    = ($urandom_range(0, 2) == 0);
      ex_opcode    = ($urandom_range(0, 1) == 0) ? LD_OPC : ALU_OPC;
      ex_we        = 1'($urandom_range(0, 1));
      ex_rd_addr   = 5'($urandom_range(0, 3));
      id_rs1_addr  = 5'($urandom_range(0, 3));
      id_rs2_addr  = 5'($urandom_range(0, 3));
      id_rs1_re    = 1'($urandom_range(0, 1));
      id_rs2_re    = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
